// File: rtl/alu_result_disp.sv
// Four-digit 7-segment display for a captured 4-bit ALU result: value, sign/tens,
// carry and a blinking overflow flag, with a decimal point marking fresh results.
module alu_result_disp #(
   parameter int unsigned BLINK_DIV = 24,
   parameter int unsigned FRESH_CYC = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] res,
   input  logic       car,
   input  logic       of,
   input  logic       res_valid,
   input  logic       sgn,
   input  logic       hold,
   output logic [7:0] seg0,
   output logic [7:0] seg1,
   output logic [7:0] seg2,
   output logic [7:0] seg3,
   output logic       busy_fresh
);

   localparam int unsigned FW = $clog2(FRESH_CYC + 1);

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_MINUS = 8'hFD;
   localparam logic [7:0] SEG_ONE   = 8'h9F;
   localparam logic [7:0] SEG_ZERO  = 8'h03;
   localparam logic [7:0] SEG_C     = 8'h63;
   localparam logic [7:0] SEG_O     = 8'h03;

   function automatic logic [7:0] digit(input logic [3:0] d);
      logic [7:0] code;
      case (d)
         4'd0:    code = 8'h03;
         4'd1:    code = 8'h9F;
         4'd2:    code = 8'h25;
         4'd3:    code = 8'h0D;
         4'd4:    code = 8'h99;
         4'd5:    code = 8'h49;
         4'd6:    code = 8'h41;
         4'd7:    code = 8'h1F;
         4'd8:    code = 8'h01;
         4'd9:    code = 8'h09;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

   logic [3:0]           res_h;
   logic                 car_h;
   logic                 of_h;
   logic                 sgn_h;
   logic [BLINK_DIV-1:0] blink_cnt;
   logic                 blink_ph;
   logic [FW-1:0]        fresh_cnt;

   logic       capture;
   logic [3:0] mag;
   logic [7:0] seg0_c;
   logic [7:0] seg1_c;
   logic [7:0] seg2_c;
   logic [7:0] seg3_c;
   logic       fresh_c;

   assign capture = res_valid & ~hold;

   // Held ALU result, captured on every valid cycle unless frozen by hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_h <= 4'd0;
         car_h <= 1'b0;
         of_h  <= 1'b0;
         sgn_h <= 1'b0;
      end else if (capture) begin
         res_h <= res;
         car_h <= car;
         of_h  <= of;
         sgn_h <= sgn;
      end
   end

   // Free-running blink prescaler; phase flips each time the counter wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else begin
         blink_cnt <= blink_cnt + BLINK_DIV'(1);
         if (&blink_cnt) blink_ph <= ~blink_ph;
      end
   end

   // Fresh window: reload on capture (no accumulation), else count down to zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fresh_cnt <= '0;
      end else if (capture) begin
         fresh_cnt <= FW'(FRESH_CYC);
      end else if (fresh_cnt != '0) begin
         fresh_cnt <= fresh_cnt - FW'(1);
      end
   end

   // Decode held state into segment codes
   always_comb begin
      mag     = res_h;
      seg1_c  = SEG_BLANK;
      fresh_c = (fresh_cnt != '0);
      if (sgn_h) begin
         if (res_h[3]) begin
            seg1_c = SEG_MINUS;
            mag    = 4'd0 - res_h;
         end
      end else if (res_h >= 4'd10) begin
         seg1_c = SEG_ONE;
         mag    = res_h - 4'd10;
      end
      seg0_c = digit(mag);
      if (fresh_c) seg0_c[0] = 1'b0;
      seg2_c = car_h ? SEG_C : SEG_BLANK;
      seg3_c = (of_h && blink_ph) ? SEG_O : SEG_BLANK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg0       <= SEG_ZERO;
         seg1       <= SEG_BLANK;
         seg2       <= SEG_BLANK;
         seg3       <= SEG_BLANK;
         busy_fresh <= 1'b0;
      end else begin
         seg0       <= seg0_c;
         seg1       <= seg1_c;
         seg2       <= seg2_c;
         seg3       <= seg3_c;
         busy_fresh <= fresh_c;
      end
   end

endmodule

// File: tb/tb_alu_result_disp.sv
// Directed bench for alu_result_disp: decode table, fresh window, hold, back-to-back,
// overflow blink and asynchronous reset.
module tb_alu_result_disp;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] res;
   logic       car;
   logic       of;
   logic       res_valid;
   logic       sgn;
   logic       hold;
   logic [7:0] seg0;
   logic [7:0] seg1;
   logic [7:0] seg2;
   logic [7:0] seg3;
   logic       busy_fresh;

   int checks = 0;
   int errors = 0;

   alu_result_disp #(.BLINK_DIV(3), .FRESH_CYC(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .res        (res),
      .car        (car),
      .of         (of),
      .res_valid  (res_valid),
      .sgn        (sgn),
      .hold       (hold),
      .seg0       (seg0),
      .seg1       (seg1),
      .seg2       (seg2),
      .seg3       (seg3),
      .busy_fresh (busy_fresh)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] r;
      logic       c;
      logic       s;
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] e2;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle capture strobe, then one more edge so the outputs show the new value
   task automatic capture(input logic [3:0] r, input logic c, input logic o, input logic s);
      res = r; car = c; of = o; sgn = s; res_valid = 1'b1;
      step();
      res_valid = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int m;
      int bad;
      logic [7:0] prev;
      logic [7:0] v1;
      logic [7:0] v2;

      vecs[0] = '{4'hD, 1'b1, 1'b1, 8'h0D, 8'hFD, 8'h63};
      vecs[1] = '{4'hF, 1'b0, 1'b0, 8'h49, 8'h9F, 8'hFF};
      vecs[2] = '{4'h8, 1'b0, 1'b1, 8'h01, 8'hFD, 8'hFF};
      vecs[3] = '{4'h7, 1'b0, 1'b1, 8'h1F, 8'hFF, 8'hFF};
      vecs[4] = '{4'hA, 1'b1, 1'b0, 8'h03, 8'h9F, 8'h63};
      vecs[5] = '{4'h9, 1'b0, 1'b0, 8'h09, 8'hFF, 8'hFF};
      vecs[6] = '{4'h0, 1'b1, 1'b1, 8'h03, 8'hFF, 8'h63};
      vecs[7] = '{4'hF, 1'b0, 1'b1, 8'h9F, 8'hFD, 8'hFF};
      vecs[8] = '{4'h4, 1'b0, 1'b0, 8'h99, 8'hFF, 8'hFF};

      rst_n = 1'b1; res = 4'd0; car = 1'b0; of = 1'b0;
      res_valid = 1'b0; sgn = 1'b0; hold = 1'b0;

      // Reset asserted between edges must act immediately
      #2 rst_n = 1'b0;
      #1;
      chk("rst_seg0", seg0, 8'h03);
      chk("rst_seg1", seg1, 8'hFF);
      chk("rst_seg2", seg2, 8'hFF);
      chk("rst_seg3", seg3, 8'hFF);
      chk("rst_busy", busy_fresh, 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Decode table with dp during the fresh window and window length
      for (int i = 0; i < 9; i++) begin
         capture(vecs[i].r, vecs[i].c, 1'b0, vecs[i].s);
         chk($sformatf("v%0d_seg0_dp", i), seg0, vecs[i].e0 & 8'hFE);
         chk($sformatf("v%0d_seg1", i), seg1, vecs[i].e1);
         chk($sformatf("v%0d_seg2", i), seg2, vecs[i].e2);
         chk($sformatf("v%0d_seg3", i), seg3, 8'hFF);
         n = 0;
         while (busy_fresh && n < 40) begin
            n++;
            step();
         end
         chk($sformatf("v%0d_fresh_len", i), n, 16);
         chk($sformatf("v%0d_seg0", i), seg0, vecs[i].e0);
      end

      // Hold overrides res_valid after the window expired
      hold = 1'b1; res_valid = 1'b1; res = 4'h7; sgn = 1'b1; car = 1'b1;
      step(); step(); step();
      chk("hold_seg0", seg0, 8'h99);
      chk("hold_seg1", seg1, 8'hFF);
      chk("hold_seg2", seg2, 8'hFF);
      chk("hold_busy", busy_fresh, 0);
      hold = 1'b0; res_valid = 1'b0;
      step();

      // Hold inside an active window does not reload it
      capture(4'h2, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (busy_fresh && n < 40) begin
         if (n == 5) begin hold = 1'b1; res_valid = 1'b1; res = 4'h7; end
         if (n == 8) begin hold = 1'b0; res_valid = 1'b0; end
         n++;
         step();
      end
      chk("hold_win_len", n, 16);
      chk("hold_win_seg0", seg0, 8'h25);

      // Back-to-back captures at edges 0 and 5
      res = 4'h3; sgn = 1'b0; car = 1'b0; of = 1'b0; res_valid = 1'b1;
      step();
      res_valid = 1'b0;
      step(); step(); step(); step();
      res = 4'hC; res_valid = 1'b1;
      step();
      res_valid = 1'b0;
      chk("b2b_e5_seg0", seg0, 8'h0C);
      step();
      chk("b2b_e6_seg0", seg0, 8'h24);
      chk("b2b_e6_seg1", seg1, 8'h9F);
      chk("b2b_e6_busy", busy_fresh, 1);
      for (int i = 0; i < 15; i++) step();
      chk("b2b_e21_busy", busy_fresh, 1);
      step();
      chk("b2b_e22_busy", busy_fresh, 0);
      chk("b2b_e22_seg0", seg0, 8'h25);

      // Overflow blink: 8-cycle half period between blank and O
      capture(4'h1, 1'b0, 1'b1, 1'b0);
      step();
      prev = seg3;
      n = 0;
      while (seg3 == prev && n < 20) begin
         n++;
         step();
      end
      chk("blink_first_toggle_timeout", (n < 20) ? 1 : 0, 1);
      v1 = seg3;
      m = 0;
      while (seg3 == v1 && m < 20) begin
         m++;
         step();
      end
      chk("blink_half_period_1", m, 8);
      v2 = seg3;
      chk("blink_values", v1 ^ v2, 8'hFC);
      m = 0;
      while (seg3 == v2 && m < 20) begin
         m++;
         step();
      end
      chk("blink_half_period_2", m, 8);

      capture(4'h1, 1'b0, 1'b0, 1'b0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (seg3 != 8'hFF) bad++;
         step();
      end
      chk("no_of_seg3_blank", bad, 0);

      // Asynchronous reset in the middle of a window with overflow set
      capture(4'hD, 1'b1, 1'b1, 1'b1);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_seg0", seg0, 8'h03);
      chk("arst_seg1", seg1, 8'hFF);
      chk("arst_seg2", seg2, 8'hFF);
      chk("arst_seg3", seg3, 8'hFF);
      chk("arst_busy", busy_fresh, 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("post_rst_seg0", seg0, 8'h03);
      chk("post_rst_seg1", seg1, 8'hFF);
      chk("post_rst_seg3", seg3, 8'hFF);
      chk("post_rst_busy", busy_fresh, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
